// File: rtl/snake_text_pkg.sv
// Shared constants for the snake text layers: glyph codes, cell geometry,
// default RGB565 colours, the per-pixel attribute record and the glyph bitmaps.
package snake_text_pkg;

  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;

  localparam logic [4:0] GLYPH_SPACE = 5'd0;
  localparam logic [4:0] GLYPH_S     = 5'd1;
  localparam logic [4:0] GLYPH_N     = 5'd2;
  localparam logic [4:0] GLYPH_A     = 5'd3;
  localparam logic [4:0] GLYPH_K     = 5'd4;
  localparam logic [4:0] GLYPH_E     = 5'd5;
  localparam logic [4:0] GLYPH_LS    = 5'd6;
  localparam logic [4:0] GLYPH_T     = 5'd7;
  localparam logic [4:0] GLYPH_R     = 5'd8;
  localparam logic [4:0] GLYPH_DIG0  = 5'd9;

  localparam logic [15:0] COLOR_BACK_DEF = 16'h0000;
  localparam logic [15:0] COLOR_FG_DEF   = 16'h5555;
  localparam logic [15:0] COLOR_SEL_DEF  = 16'hF00F;

  // Per-pixel attributes that travel alongside the glyph ROM lookup.
  typedef struct packed {
    logic       valid;
    logic       hit;
    logic       sel_line;
    logic       blink;
    logic [2:0] bit_idx;
  } text_attr_t;

  // 8x16 bitmaps; row r occupies bits [127-8r -: 8], MSB is the leftmost pixel.
  function automatic logic [127:0] glyph_bitmap(input logic [4:0] code);
    logic [127:0] bm;
    bm = '0;
    case (code)
      GLYPH_S:            bm = 128'h0000003E6360603E0303633E00000000;
      GLYPH_N:            bm = 128'h00000000006E33333333333300000000;
      GLYPH_A:            bm = 128'h00000000003C063E6666663B00000000;
      GLYPH_K:            bm = 128'h0000606060666C78786C666600000000;
      GLYPH_E:            bm = 128'h00000000003C667E6060663C00000000;
      GLYPH_LS:           bm = 128'h00000000003E60603C06067C00000000;
      GLYPH_T:            bm = 128'h00001818187E181818181B0E00000000;
      GLYPH_R:            bm = 128'h00000000006E3B303030303000000000;
      GLYPH_DIG0:         bm = 128'h00003C66666E76666666663C00000000;
      GLYPH_DIG0 + 5'd1:  bm = 128'h00001838781818181818187E00000000;
      GLYPH_DIG0 + 5'd2:  bm = 128'h00003C66060C18306060667E00000000;
      GLYPH_DIG0 + 5'd3:  bm = 128'h00003C6606061C060606663C00000000;
      GLYPH_DIG0 + 5'd4:  bm = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      GLYPH_DIG0 + 5'd5:  bm = 128'h00007E6060607C060606663C00000000;
      GLYPH_DIG0 + 5'd6:  bm = 128'h00001C3060607C666666663C00000000;
      GLYPH_DIG0 + 5'd7:  bm = 128'h00007E66060C18181818181800000000;
      GLYPH_DIG0 + 5'd8:  bm = 128'h00003C6666663C666666663C00000000;
      GLYPH_DIG0 + 5'd9:  bm = 128'h00003C6666663E0606060C3800000000;
      default:            bm = '0;
    endcase
    return bm;
  endfunction

endpackage

// File: rtl/snake_glyph_rom.sv
// Shared 32-entry 8x16 glyph ROM with a one-cycle registered row output.
// Also used by the score renderer.
module snake_glyph_rom
  import snake_text_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [4:0] code,
  input  logic [3:0] row,
  output logic [7:0] data
);

  logic [127:0] bitmap;

  assign bitmap = glyph_bitmap(code);

  // NOTE: sequential state is written with <= only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data <= '0;
    end else begin
      data <= 8'(bitmap >> {4'd15 - row, 3'b000});
    end
  end

endmodule

// File: rtl/snake_text_overlay.sv
// Multi-line text layer: writable character buffer, scaled glyph rendering,
// and a blinking cursor line. Three-stage pipeline from coordinates to colour.
module snake_text_overlay
  import snake_text_pkg::*;
#(
  parameter int                   N_LINES      = 2,
  parameter int                   MAX_CHARS    = 8,
  parameter int                   SCALE_SHIFT  = 3,
  parameter logic [8*N_LINES-1:0] LINE_X0      = {8'd25, 8'd10},
  parameter logic [8*N_LINES-1:0] LINE_Y0      = {8'd26, 8'd10},
  parameter int                   BLINK_FRAMES = 30,
  parameter logic [15:0]          COLOR_BACK   = COLOR_BACK_DEF,
  parameter logic [15:0]          COLOR_FG     = COLOR_FG_DEF,
  parameter logic [15:0]          COLOR_SEL    = COLOR_SEL_DEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [10:0]                  pixel_xpos,
  input  logic [10:0]                  pixel_ypos,
  input  logic                         frame_start,
  input  logic                         sel_up,
  input  logic                         sel_down,
  input  logic                         wr_en,
  input  logic [$clog2(N_LINES)-1:0]   wr_line,
  input  logic [$clog2(MAX_CHARS)-1:0] wr_col,
  input  logic [4:0]                   wr_code,
  output logic [15:0]                  pixel_text,
  output logic                         pixel_hit,
  output logic [$clog2(N_LINES)-1:0]   sel_idx
);

  localparam int          LW     = $clog2(N_LINES);
  localparam int          CW     = $clog2(MAX_CHARS);
  localparam int          BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [11:0] SPAN_X = 12'(CHAR_W * MAX_CHARS);
  localparam logic [11:0] SPAN_Y = 12'(CHAR_H);

  // ---------------- cursor and blink ----------------
  logic          up_q, dn_q;
  logic          up_edge, dn_edge, cursor_move;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  assign up_edge     = sel_up & ~up_q;
  assign dn_edge     = sel_down & ~dn_q;
  assign cursor_move = up_edge ^ dn_edge;

  // A cursor move restarts the blink cycle so the new line shows at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      sel_idx     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      up_q <= sel_up;
      dn_q <= sel_down;
      if (cursor_move) begin
        if (up_edge) begin
          sel_idx <= (sel_idx == '0) ? LW'(N_LINES - 1) : sel_idx - 1'b1;
        end else begin
          sel_idx <= (sel_idx == LW'(N_LINES - 1)) ? '0 : sel_idx + 1'b1;
        end
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (frame_start) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // ---------------- character buffer ----------------
  logic [4:0] char_buf [N_LINES][MAX_CHARS];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the buffer is a register array, so it takes the async reset; a RAM macro could not.
      for (int l = 0; l < N_LINES; l++) begin
        for (int c = 0; c < MAX_CHARS; c++) begin
          char_buf[l][c] <= GLYPH_SPACE;
        end
      end
    end else if (wr_en && (int'(wr_line) < N_LINES) && (int'(wr_col) < MAX_CHARS)) begin
      char_buf[wr_line][wr_col] <= wr_code;
    end
  end

  // ---------------- per-line hit test ----------------
  logic [10:0]        xs, ys;
  logic [N_LINES-1:0] line_hit;
  logic [CW-1:0]      line_col [N_LINES];
  logic [3:0]         line_row [N_LINES];
  logic [2:0]         line_bit [N_LINES];

  assign xs = pixel_xpos >> SCALE_SHIFT;
  assign ys = pixel_ypos >> SCALE_SHIFT;

  for (genvar l = 0; l < N_LINES; l++) begin : g_line
    logic [10:0] x0, y0;

    assign x0 = 11'(LINE_X0[8*l +: 8]);
    assign y0 = 11'(LINE_Y0[8*l +: 8]);

    assign line_hit[l] = (xs >= x0) && ({1'b0, xs} < {1'b0, x0} + SPAN_X) &&
                         (ys >= y0) && ({1'b0, ys} < {1'b0, y0} + SPAN_Y);
    assign line_col[l] = CW'((xs - x0) >> 3);
    assign line_row[l] = 4'(ys - y0);
    assign line_bit[l] = 3'd7 - 3'(xs - x0);
  end

  // Lowest-indexed hit line wins when lines overlap.
  logic          hit_any;
  logic [LW-1:0] hit_line;
  logic [CW-1:0] hit_col;
  logic [3:0]    hit_row;
  logic [2:0]    hit_bit;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    hit_any  = 1'b0;
    hit_line = '0;
    hit_col  = '0;
    hit_row  = '0;
    hit_bit  = '0;
    for (int l = N_LINES - 1; l >= 0; l--) begin
      if (line_hit[l]) begin
        hit_any  = 1'b1;
        hit_line = LW'(l);
        hit_col  = line_col[l];
        hit_row  = line_row[l];
        hit_bit  = line_bit[l];
      end
    end
  end

  // ---------------- pipeline ----------------
  text_attr_t s1_attr, s2_attr;
  logic [4:0] s1_code;
  logic [3:0] s1_row;
  logic [7:0] rom_row;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_attr <= '0;
      s1_code <= GLYPH_SPACE;
      s1_row  <= '0;
    end else begin
      s1_attr.valid    <= 1'b1;
      s1_attr.hit      <= hit_any;
      s1_attr.sel_line <= hit_any && (hit_line == sel_idx);
      s1_attr.blink    <= blink_phase;
      s1_attr.bit_idx  <= hit_bit;
      s1_row           <= hit_row;
      s1_code          <= hit_any ? char_buf[hit_line][hit_col] : GLYPH_SPACE;
    end
  end

  snake_glyph_rom u_glyph_rom (
    .clk  (clk),
    .rstn (rstn),
    .code (s1_code),
    .row  (s1_row),
    .data (rom_row)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_attr <= '0;
    end else begin
      s2_attr <= s1_attr;
    end
  end

  logic        glyph_on;
  logic [15:0] color_next;

  assign glyph_on = s2_attr.valid && s2_attr.hit && rom_row[s2_attr.bit_idx];

  always_comb begin
    color_next = COLOR_BACK;
    if (glyph_on) begin
      if (!s2_attr.sel_line) begin
        color_next = COLOR_FG;
      end else if (!s2_attr.blink) begin
        color_next = COLOR_SEL;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pixel_text <= COLOR_BACK;
      pixel_hit  <= 1'b0;
    end else begin
      pixel_text <= color_next;
      pixel_hit  <= s2_attr.valid && s2_attr.hit;
    end
  end

endmodule
